fifo_cmd_reader: RTL and testbench
==================================

# fifo_cmd_reader

Read side of the one-bit command FIFO: it pulls serial bits out of the FIFO, locates frame start bits, and deserialises each frame into a 3-bit opcode and a 20-bit command. Completed frames are presented on a valid/ready output port with a parity-error flag. It sits in the `fifo_clk` domain, between the single-bit FIFO and the command consumer.

## Interface
Parameters: none. Frame geometry is fixed by the shared package.
- `fifo_clk` in 1: sole clock; all logic is on the rising edge.
- `fifo_rst_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO has no readable bit.
- `fifo_req` out 1: read request; pops one bit at this edge.
- `fifo_bit` in 1: read data; valid on the edge one cycle after `fifo_req`.
- `cmd_valid` out 1: the output word is held.
- `cmd_ready` in 1: the consumer accepts the word.
- `opcode` out 3: decoded opcode.
- `command` out 20: decoded command.
- `cmd_err` out 1: parity error on the held word.

## Operation
- Frame is 25 bits, first to last:
  - start bit `1`
  - `opcode[2:0]`, MSB first
  - `command[19:0]`, MSB first
  - even-parity bit, chosen so the XOR of the 23 payload bits and the parity bit is 0
- Any `0` bits before a start bit are discarded.
- States:
  - **HUNT**: issue `fifo_req` only when `!fifo_empty` and no bit is in flight, so at most one request every 2 cycles. An arriving `0` is discarded. An arriving `1` moves the block to DATA with `rx_cnt=0` and `req_cnt=0`.
  - **DATA**: issue `fifo_req` when `!fifo_empty && req_cnt<24`. For the parity request (`req_cnt==23`), also require `!cmd_valid`. Each arriving bit shifts into a 23-bit shift register and increments `rx_cnt`, while a running XOR accumulates. When the bit arriving at `rx_cnt==23` (parity) lands:
    - load `{opcode,command}` from the shift register
    - set `cmd_err` to the XOR result
    - set `cmd_valid`
    - return to HUNT
- The parity gate guarantees the output register is empty when a frame completes, so no frame is ever dropped or overwritten.
- Output handshake: the transfer happens at any edge with `cmd_valid && cmd_ready`, and `cmd_valid` clears at that edge. `opcode`, `command` and `cmd_err` are stable while `cmd_valid` is high.
- Counters: `req_cnt` and `rx_cnt` are 5-bit and never wrap; their range is bounded at 24.

## Timing
- Reset values:
  - `fifo_req=0`, `cmd_valid=0`, `cmd_err=0`
  - `opcode=0`, `command=0`
  - state HUNT, counters 0, in-flight flag 0
- Reset asserted mid-frame: the partial frame and any in-flight bit are abandoned, and the block resumes in HUNT.
- `fifo_req` is combinational from state, counters, `fifo_empty` and `cmd_valid`. It must never be high while `fifo_empty=1`.
- Read latency is 1: a bit requested at edge N is sampled at edge N+1.
- With a FIFO that is never empty, DATA requests on consecutive cycles. `cmd_valid` rises at the edge after the parity request, giving 24 DATA cycles plus hunt time per frame.
- If the FIFO goes empty mid-frame, the block waits in DATA with no timeout.
- The start bit and the first payload request may overlap only in DATA; HUNT never has 2 bits outstanding.
- `cmd_ready` held low: DATA requests proceed up to `req_cnt==23`, then stall until the held word is taken. The parity request may issue at the same edge that `cmd_valid` clears? No: it waits for `cmd_valid==0` as seen combinationally, so it issues one cycle after the transfer.

## Structure
- Shared package `cmd_fifo_pkg` holds:
  - `OPCODE_W=3`, `COMMAND_W=20`
  - `PAYLOAD_W=23`, `FRAME_W=25`
  - the state enum `{HUNT, DATA}`
- The serialising writer imports the same package.
- No sub-module; the shift register, counters and FSM live in one module.

## Test plan
- Frame `1`, `001`, `0x12345`, parity `0`, FIFO always non-empty, `cmd_ready=1` -> one word: opcode 1, command 20'h12345, `cmd_err=0`; `cmd_valid` high for exactly 1 cycle.
- Five leading `0`s, then the frame for opcode 2 / command 20'h6789a with parity `1` -> leading `0`s discarded; word opcode 2, command 20'h6789a, `cmd_err=0`.
- Same frame as above with the parity bit flipped -> word delivered with `cmd_err=1`; the next valid frame decodes with `cmd_err=0`.
- Two back-to-back frames with `cmd_ready=0` for 40 cycles -> first word held and stable; `fifo_req` stalls at `req_cnt==23` of the second frame; after `cmd_ready=1`, both words arrive in order, none lost.
- `fifo_empty` toggled every other cycle during a frame -> `fifo_req` never asserted while empty; word is correct.
- `fifo_rst_n` pulsed low at `rx_cnt==10` -> all outputs return to reset values immediately; the next complete frame decodes correctly.

Source files
------------

// File: rtl/cmd_fifo_pkg.sv
// Shared definitions for the one-bit command FIFO: frame geometry, counter
// sizing, reader FSM states and the decoded word layout.
package cmd_fifo_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned COMMAND_W = 20;
  localparam int unsigned PAYLOAD_W = OPCODE_W + COMMAND_W;  // 23
  localparam int unsigned FRAME_W   = PAYLOAD_W + 2;         // start + payload + parity
  localparam int unsigned CNT_W     = 5;

  // Bit index of the parity bit within the post-start stream (0-based)
  localparam logic [CNT_W-1:0] PARITY_IDX = CNT_W'(PAYLOAD_W);       // 23
  // Number of post-start bits in a frame; request counter saturates here
  localparam logic [CNT_W-1:0] DATA_BITS  = CNT_W'(PAYLOAD_W + 1);   // 24

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [COMMAND_W-1:0] command;
  } cmd_word_t;

  // Even parity over the payload: the writer appends this bit so that the
  // XOR of payload and parity is zero.
  function automatic logic frame_parity(input logic [PAYLOAD_W-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/fifo_cmd_reader_if.sv
// Decoded-command output port: valid/ready handshake carrying opcode,
// command and parity-error flag.
interface fifo_cmd_reader_if;
  import cmd_fifo_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [COMMAND_W-1:0] command;
  logic                 cmd_err;

  // Producer side (the reader)
  modport master (
    output cmd_valid,
    output opcode,
    output command,
    output cmd_err,
    input  cmd_ready
  );

  // Consumer side
  modport slave (
    input  cmd_valid,
    input  opcode,
    input  command,
    input  cmd_err,
    output cmd_ready
  );

endinterface

// File: rtl/fifo_cmd_reader.sv
// Read side of the one-bit command FIFO. Pops serial bits, hunts for the
// start bit, deserialises opcode/command, checks even parity and presents
// the result on a valid/ready port.
module fifo_cmd_reader
  import cmd_fifo_pkg::*;
(
  input  logic              fifo_clk,
  input  logic              fifo_rst_n,
  input  logic              fifo_empty,
  output logic              fifo_req,
  input  logic              fifo_bit,
  fifo_cmd_reader_if.master cmd
);

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     req_cnt;
  logic [CNT_W-1:0]     req_cnt_next;
  logic [CNT_W-1:0]     rx_cnt;
  logic [CNT_W-1:0]     rx_cnt_next;
  logic [PAYLOAD_W-1:0] shift;
  logic [PAYLOAD_W-1:0] shift_next;
  logic                 par;
  logic                 par_next;
  logic                 in_flight;
  logic                 in_flight_next;
  logic                 valid_q;
  logic                 valid_next;
  cmd_word_t            word_q;
  cmd_word_t            word_next;
  logic                 err_q;
  logic                 err_next;

  // State, counters, shift register and output holding register
  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      state     <= HUNT;
      req_cnt   <= '0;
      rx_cnt    <= '0;
      shift     <= '0;
      par       <= 1'b0;
      in_flight <= 1'b0;
      valid_q   <= 1'b0;
      word_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      req_cnt   <= req_cnt_next;
      rx_cnt    <= rx_cnt_next;
      shift     <= shift_next;
      par       <= par_next;
      in_flight <= in_flight_next;
      valid_q   <= valid_next;
      word_q    <= word_next;
      err_q     <= err_next;
    end
  end

  // Read-request generation, bit reception, frame completion and handshake
  always_comb begin
    state_next   = state;
    req_cnt_next = req_cnt;
    rx_cnt_next  = rx_cnt;
    shift_next   = shift;
    par_next     = par;
    valid_next   = valid_q;
    word_next    = word_q;
    err_next     = err_q;
    fifo_req     = 1'b0;

    // HUNT keeps at most one bit outstanding so a start bit is seen before
    // any payload is requested. DATA streams freely, except the parity pop
    // waits until the output register is empty so no frame is overwritten.
    case (state)
      HUNT:    fifo_req = !fifo_empty && !in_flight;
      DATA:    fifo_req = !fifo_empty && (req_cnt < DATA_BITS) &&
                          ((req_cnt != PARITY_IDX) || !valid_q);
      default: fifo_req = 1'b0;
    endcase
    // No pops while reset is held
    fifo_req = fifo_req && fifo_rst_n;

    in_flight_next = fifo_req;

    if (valid_q && cmd.cmd_ready) begin
      valid_next = 1'b0;
    end

    case (state)
      HUNT: begin
        if (in_flight && fifo_bit) begin
          state_next   = DATA;
          rx_cnt_next  = '0;
          req_cnt_next = '0;
          par_next     = 1'b0;
        end
      end
      DATA: begin
        if (fifo_req) begin
          req_cnt_next = req_cnt + CNT_W'(1);
        end
        if (in_flight) begin
          if (rx_cnt == PARITY_IDX) begin
            word_next    = shift;
            err_next     = par ^ fifo_bit;
            valid_next   = 1'b1;
            state_next   = HUNT;
            rx_cnt_next  = '0;
            req_cnt_next = '0;
          end else begin
            shift_next  = {shift[PAYLOAD_W-2:0], fifo_bit};
            par_next    = par ^ fifo_bit;
            rx_cnt_next = rx_cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.opcode    = word_q.opcode;
  assign cmd.command   = word_q.command;
  assign cmd.cmd_err   = err_q;

endmodule

// File: tb/tb_fifo_cmd_reader.sv
// Self-checking bench for fifo_cmd_reader: a queue-backed FIFO model feeds
// serial frames; expected words go to a scoreboard when frames are queued
// and are compared as the DUT hands words over.
module tb_fifo_cmd_reader;

  typedef struct packed {
    logic [2:0]  op;
    logic [19:0] cmd;
    logic        err;
  } word_t;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic fifo_empty = 1'b1;
  logic fifo_req;
  logic fifo_bit   = 1'b0;

  fifo_cmd_reader_if ifc();

  fifo_cmd_reader dut (
    .fifo_clk   (clk),
    .fifo_rst_n (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_req   (fifo_req),
    .fifo_bit   (fifo_bit),
    .cmd        (ifc)
  );

  always #5 clk = ~clk;

  logic  bitq[$];
  word_t sb[$];
  int    pops = 0;

  int    checks   = 0;
  int    passed   = 0;
  int    req_viol = 0;
  int    vcnt     = 0;
  logic  ready_nxt = 1'b1;
  logic  gap       = 1'b0;
  logic  xfer;
  logic  vld;
  word_t got;

  // FIFO model: a request at edge N presents the popped bit for edge N+1
  always @(posedge clk) begin
    if (fifo_req && bitq.size() != 0) begin
      fifo_bit <= bitq.pop_front();
      pops     <= pops + 1;
    end
  end

  // Advance one cycle: inputs change at the falling edge, outputs sampled 1ns later
  task automatic cycle();
    @(negedge clk);
    ifc.cmd_ready = ready_nxt;
    fifo_empty    = (bitq.size() == 0) || gap;
    #1;
    if (fifo_req && fifo_empty) req_viol++;
    vld  = ifc.cmd_valid;
    xfer = vld && ifc.cmd_ready;
    got  = {ifc.opcode, ifc.command, ifc.cmd_err};
    if (vld) vcnt++;
  endtask

  task automatic push_frame(input logic [2:0] op, input logic [19:0] cmd,
                            input logic flip, input int lead);
    logic [24:0] f;
    f = {1'b1, op, cmd, (^{op, cmd}) ^ flip};
    repeat (lead) bitq.push_back(1'b0);
    for (int i = 24; i >= 0; i--) bitq.push_back(f[i]);
    sb.push_back({op, cmd, flip});
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ready_nxt = 1'b1;
    bitq.push_back(1'b0);
    cycle();
    cycle();
    checks++;
    if (fifo_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", fifo_req);
    else passed++;
    checks++;
    if (vld !== 1'b0) $display("FAIL reset_valid: got %b expected 0", vld);
    else passed++;
    checks++;
    if (got !== word_t'(0)) $display("FAIL reset_word: got %h expected 0", got);
    else passed++;
    rst_n = 1'b1;
    repeat (4) cycle();
    checks++;
    if (bitq.size() != 0 || vld !== 1'b0)
      $display("FAIL reset_zero_discard: got left=%0d valid=%b expected 0/0", bitq.size(), vld);
    else passed++;
  endtask

  task automatic test_basic();
    word_t exp;
    int    first;
    first = -1;
    vcnt  = 0;
    ready_nxt = 1'b1;
    push_frame(3'd1, 20'h12345, 1'b0, 0);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      cycle();
      if (vld && first < 0) first = c + 1;
      if (xfer) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) $display("FAIL basic_word: got %h expected %h", got, exp);
        else passed++;
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL basic_timeout: got %0d pending expected 0", sb.size());
    else passed++;
    checks++;
    if (first != 28) $display("FAIL basic_latency: got %0d expected 28", first);
    else passed++;
    repeat (3) cycle();
    checks++;
    if (vcnt != 1) $display("FAIL basic_valid_cycles: got %0d expected 1", vcnt);
    else passed++;
  endtask

  task automatic test_leading_zeros();
    word_t exp;
    int    first;
    first = -1;
    push_frame(3'd2, 20'h6789a, 1'b0, 5);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      cycle();
      if (vld && first < 0) first = c + 1;
      if (xfer) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) $display("FAIL lead_word: got %h expected %h", got, exp);
        else passed++;
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL lead_timeout: got %0d pending expected 0", sb.size());
    else passed++;
    checks++;
    if (first != 38) $display("FAIL lead_latency: got %0d expected 38", first);
    else passed++;
  endtask

  task automatic test_parity_error();
    word_t exp;
    push_frame(3'd2, 20'h6789a, 1'b1, 0);
    push_frame(3'd0, 20'hfffff, 1'b0, 1);
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      cycle();
      if (xfer) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) $display("FAIL parity_word: got %h expected %h", got, exp);
        else passed++;
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL parity_timeout: got %0d pending expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    word_t exp;
    word_t held;
    logic  have;
    int    stab;
    int    early;
    have  = 1'b0;
    held  = '0;
    stab  = 0;
    early = 0;
    ready_nxt = 1'b0;
    push_frame(3'd5, 20'habcde, 1'b0, 0);
    push_frame(3'd7, 20'h00001, 1'b0, 0);
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (xfer) early++;
      if (vld) begin
        if (!have) begin
          have = 1'b1;
          held = got;
        end else if (got !== held) stab++;
      end
    end
    exp = sb[0];
    checks++;
    if (!have || held !== exp) $display("FAIL b2b_held: got %h (seen=%b) expected %h", held, have, exp);
    else passed++;
    checks++;
    if (stab != 0 || early != 0 || vld !== 1'b1)
      $display("FAIL b2b_stable: got changes=%0d xfers=%0d valid=%b expected 0/0/1", stab, early, vld);
    else passed++;
    checks++;
    if (fifo_req !== 1'b0 || bitq.size() != 1)
      $display("FAIL b2b_stall: got req=%b left=%0d expected 0/1", fifo_req, bitq.size());
    else passed++;
    ready_nxt = 1'b1;
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      cycle();
      if (xfer) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) $display("FAIL b2b_word: got %h expected %h", got, exp);
        else passed++;
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL b2b_timeout: got %0d pending expected 0", sb.size());
    else passed++;
  endtask

  task automatic test_empty_gaps();
    word_t exp;
    push_frame(3'd3, 20'hf0f0f, 1'b0, 2);
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      gap = ~gap;
      cycle();
      if (xfer) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) $display("FAIL gap_word: got %h expected %h", got, exp);
        else passed++;
      end
    end
    gap = 1'b0;
    checks++;
    if (sb.size() != 0) $display("FAIL gap_timeout: got %0d pending expected 0", sb.size());
    else passed++;
    checks++;
    if (req_viol != 0) $display("FAIL req_while_empty: got %0d expected 0", req_viol);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    word_t exp;
    int    base;
    int    stray;
    stray = 0;
    base  = pops;
    push_frame(3'd4, 20'h55aa5, 1'b0, 0);
    for (int c = 0; c < 100 && (pops - base) < 12; c++) cycle();
    checks++;
    if (pops - base != 12) $display("FAIL midrst_reach: got %0d pops expected 12", pops - base);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_req !== 1'b0 || ifc.cmd_valid !== 1'b0)
      $display("FAIL midrst_ctrl: got req=%b valid=%b expected 0/0", fifo_req, ifc.cmd_valid);
    else passed++;
    checks++;
    if ({ifc.opcode, ifc.command, ifc.cmd_err} !== 24'h0)
      $display("FAIL midrst_word: got %h expected 0", {ifc.opcode, ifc.command, ifc.cmd_err});
    else passed++;
    bitq.delete();
    sb.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
    push_frame(3'd6, 20'h0beef, 1'b0, 2);
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      cycle();
      if (xfer) begin
        exp = sb.pop_front();
        checks++;
        if (got !== exp) $display("FAIL midrst_next_word: got %h expected %h", got, exp);
        else passed++;
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL midrst_timeout: got %0d pending expected 0", sb.size());
    else passed++;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (vld) stray++;
    end
    checks++;
    if (stray != 0) $display("FAIL midrst_stray: got %0d extra valid cycles expected 0", stray);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zeros();
    test_parity_error();
    test_back_to_back();
    test_empty_gaps();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
